// File: rtl/spi_cmd_handler.sv
// spi_cmd_handler: decodes bytes received by the SPI slave, builds the reply
// byte for the slave TX buffer, and keeps a scratch register plus command and
// error counters for bring-up with the SPI master.
module spi_cmd_handler #(
    parameter int          STATE_WIDTH = 2,
    parameter logic [7:0]  ERR_BYTE    = 8'hEE,
    parameter logic [7:0]  ACK_BYTE    = 8'hAC
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_RX_DV,
    input  logic [7:0]             i_RX_Byte,
    input  logic                   i_CS_n,
    input  logic [STATE_WIDTH-1:0] i_State,
    output logic                   o_TX_DV,
    output logic [7:0]             o_TX_Byte,
    output logic [7:0]             o_Reg,
    output logic [7:0]             o_Cmd_Count,
    output logic [7:0]             o_Err_Count
);

    // Command opcodes seen in IDLE.
    localparam logic [7:0] CMD_NOP       = 8'h00;
    localparam logic [7:0] CMD_READ_REG  = 8'h01;
    localparam logic [7:0] CMD_GET_COUNT = 8'h02;
    localparam logic [7:0] CMD_WRITE_REG = 8'h81;
    localparam logic [7:0] CMD_ECHO      = 8'hA5;
    localparam logic [7:0] CMD_GET_STATE = 8'hFF;

    // Decoder states.
    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_ARG = 1'b1;

    // Pending opcode held while waiting for the argument byte.
    localparam logic [0:0] OP_WRITE = 1'b0;
    localparam logic [0:0] OP_ECHO  = 1'b1;

    logic [0:0] r_State;
    logic [0:0] r_Pend_Op;
    logic       r_TX_DV;
    logic [7:0] r_TX_Byte;
    logic [7:0] r_Reg;
    logic [7:0] r_Cmd_Count;
    logic [7:0] r_Err_Count;

    logic       r_CS_Meta;
    logic       r_CS_Sync;
    logic       r_CS_Prev;

    logic       w_CS_Rise;
    logic [0:0] w_Next_State;
    logic [0:0] w_Next_Pend_Op;
    logic       w_Reply_Valid;
    logic [7:0] w_Reply_Byte;
    logic       w_Cmd_Inc;
    logic       w_Err_Inc;
    logic       w_Reg_Load;
    logic [7:0] w_State_Ext;

    assign w_State_Ext = 8'(i_State);
    assign w_CS_Rise   = r_CS_Sync & ~r_CS_Prev;

    // Synchronise the raw chip select and keep one delayed copy for edge detect.
    always_ff @(posedge i_Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours, as real hardware does.
        if (i_Rst) begin
            r_CS_Meta <= 1'b1;
            r_CS_Sync <= 1'b1;
            r_CS_Prev <= 1'b1;
        end else begin
            r_CS_Meta <= i_CS_n;
            r_CS_Sync <= r_CS_Meta;
            r_CS_Prev <= r_CS_Sync;
        end
    end

    // Decode the received byte (or a CS abort) into next state and actions.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_Next_State   = r_State;
        w_Next_Pend_Op = r_Pend_Op;
        w_Reply_Valid  = 1'b0;
        w_Reply_Byte   = r_TX_Byte;
        w_Cmd_Inc      = 1'b0;
        w_Err_Inc      = 1'b0;
        w_Reg_Load     = 1'b0;

        if (i_RX_DV) begin
            if (r_State == ST_IDLE) begin
                case (i_RX_Byte)
                    CMD_GET_STATE: begin
                        w_Reply_Valid = 1'b1;
                        w_Reply_Byte  = w_State_Ext;
                        w_Cmd_Inc     = 1'b1;
                    end
                    CMD_READ_REG: begin
                        w_Reply_Valid = 1'b1;
                        w_Reply_Byte  = r_Reg;
                        w_Cmd_Inc     = 1'b1;
                    end
                    CMD_GET_COUNT: begin
                        w_Reply_Valid = 1'b1;
                        w_Reply_Byte  = r_Cmd_Count;
                        w_Cmd_Inc     = 1'b1;
                    end
                    CMD_WRITE_REG: begin
                        w_Cmd_Inc      = 1'b1;
                        w_Next_State   = ST_WAIT_ARG;
                        w_Next_Pend_Op = OP_WRITE;
                    end
                    CMD_ECHO: begin
                        w_Cmd_Inc      = 1'b1;
                        w_Next_State   = ST_WAIT_ARG;
                        w_Next_Pend_Op = OP_ECHO;
                    end
                    CMD_NOP: begin
                        // Dummy byte used to clock out the previous reply.
                    end
                    default: begin
                        w_Reply_Valid = 1'b1;
                        w_Reply_Byte  = ERR_BYTE;
                        w_Err_Inc     = 1'b1;
                    end
                endcase
            end else begin
                // Argument byte: never counted as a command.
                w_Reply_Valid = 1'b1;
                w_Next_State  = ST_IDLE;
                if (r_Pend_Op == OP_WRITE) begin
                    w_Reg_Load   = 1'b1;
                    w_Reply_Byte = ACK_BYTE;
                end else begin
                    w_Reply_Byte = i_RX_Byte;
                end
            end
            // A transaction ending with this byte cannot carry an argument.
            if (w_CS_Rise) begin
                w_Next_State = ST_IDLE;
            end
        end else if (w_CS_Rise && (r_State == ST_WAIT_ARG)) begin
            // Master deselected before sending the argument.
            w_Next_State = ST_IDLE;
            w_Err_Inc    = 1'b1;
        end
    end

    // Register state, reply, scratch register and counters.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State     <= ST_IDLE;
            r_Pend_Op   <= OP_WRITE;
            r_TX_DV     <= 1'b0;
            r_TX_Byte   <= 8'h00;
            r_Reg       <= 8'h00;
            r_Cmd_Count <= 8'h00;
            r_Err_Count <= 8'h00;
        end else begin
            r_State   <= w_Next_State;
            r_Pend_Op <= w_Next_Pend_Op;
            r_TX_DV   <= w_Reply_Valid;
            r_TX_Byte <= w_Reply_Byte;
            if (w_Reg_Load) begin
                r_Reg <= i_RX_Byte;
            end
            if (w_Cmd_Inc) begin
                r_Cmd_Count <= r_Cmd_Count + 8'd1;
            end
            if (w_Err_Inc && (r_Err_Count != 8'hFF)) begin
                r_Err_Count <= r_Err_Count + 8'd1;
            end
        end
    end

    assign o_TX_DV     = r_TX_DV;
    assign o_TX_Byte   = r_TX_Byte;
    assign o_Reg       = r_Reg;
    assign o_Cmd_Count = r_Cmd_Count;
    assign o_Err_Count = r_Err_Count;

endmodule

// File: tb/tb_spi_cmd_handler.sv
// tb_spi_cmd_handler: directed vectors for spi_cmd_handler with
// hand-computed expected replies, counters and scratch register values.
module tb_spi_cmd_handler;

    logic       i_Clk = 1'b0;
    logic       i_Rst;
    logic       i_RX_DV;
    logic [7:0] i_RX_Byte;
    logic       i_CS_n;
    logic [1:0] i_State;
    logic       o_TX_DV;
    logic [7:0] o_TX_Byte;
    logic [7:0] o_Reg;
    logic [7:0] o_Cmd_Count;
    logic [7:0] o_Err_Count;

    int n_total = 0;
    int n_bad   = 0;
    logic seen_dv;

    spi_cmd_handler #(
        .STATE_WIDTH(2),
        .ERR_BYTE(8'hEE),
        .ACK_BYTE(8'hAC)
    ) dut (
        .i_Clk(i_Clk),
        .i_Rst(i_Rst),
        .i_RX_DV(i_RX_DV),
        .i_RX_Byte(i_RX_Byte),
        .i_CS_n(i_CS_n),
        .i_State(i_State),
        .o_TX_DV(o_TX_DV),
        .o_TX_Byte(o_TX_Byte),
        .o_Reg(o_Reg),
        .o_Cmd_Count(o_Cmd_Count),
        .o_Err_Count(o_Err_Count)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one byte for one clock; returns at the negedge where the reply is visible.
    task automatic rx(input logic [7:0] b);
        @(negedge i_Clk);
        i_RX_DV   = 1'b1;
        i_RX_Byte = b;
        @(negedge i_Clk);
        i_RX_DV   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge i_Clk);
        i_Rst = 1'b1;
        @(negedge i_Clk);
        @(negedge i_Clk);
        i_Rst = 1'b0;
    endtask

    initial begin
        i_Rst     = 1'b1;
        i_RX_DV   = 1'b0;
        i_RX_Byte = 8'h00;
        i_CS_n    = 1'b1;
        i_State   = 2'b10;
        do_reset();
        check("rst_tx_dv", 16'(o_TX_DV), 16'h0);
        check("rst_tx_byte", 16'(o_TX_Byte), 16'h00);
        check("rst_reg", 16'(o_Reg), 16'h00);
        check("rst_cmd", 16'(o_Cmd_Count), 16'h00);
        check("rst_err", 16'(o_Err_Count), 16'h00);
        i_CS_n = 1'b0;
        repeat (4) @(negedge i_Clk);

        // GET_STATE
        rx(8'hFF);
        check("gs_dv", 16'(o_TX_DV), 16'h1);
        check("gs_byte", 16'(o_TX_Byte), 16'h02);
        check("gs_cmd", 16'(o_Cmd_Count), 16'h01);
        @(negedge i_Clk);
        check("gs_dv_pulse", 16'(o_TX_DV), 16'h0);

        // WRITE_REG 0x5C, then READ_REG
        rx(8'h81);
        check("wr_op_dv", 16'(o_TX_DV), 16'h0);
        check("wr_op_cmd", 16'(o_Cmd_Count), 16'h02);
        rx(8'h5C);
        check("wr_arg_dv", 16'(o_TX_DV), 16'h1);
        check("wr_ack", 16'(o_TX_Byte), 16'hAC);
        check("wr_reg", 16'(o_Reg), 16'h5C);
        check("wr_arg_cmd", 16'(o_Cmd_Count), 16'h02);
        rx(8'h01);
        check("rd_byte", 16'(o_TX_Byte), 16'h5C);
        check("rd_cmd", 16'(o_Cmd_Count), 16'h03);

        // ECHO 0xFF, then NOP
        rx(8'hA5);
        check("echo_op_dv", 16'(o_TX_DV), 16'h0);
        check("echo_op_cmd", 16'(o_Cmd_Count), 16'h04);
        rx(8'hFF);
        check("echo_dv", 16'(o_TX_DV), 16'h1);
        check("echo_byte", 16'(o_TX_Byte), 16'hFF);
        check("echo_cmd", 16'(o_Cmd_Count), 16'h04);
        rx(8'h00);
        check("nop_dv", 16'(o_TX_DV), 16'h0);
        check("nop_cmd", 16'(o_Cmd_Count), 16'h04);
        check("nop_err", 16'(o_Err_Count), 16'h00);
        check("nop_hold", 16'(o_TX_Byte), 16'hFF);

        // Unknown command
        rx(8'h37);
        check("unk_byte", 16'(o_TX_Byte), 16'hEE);
        check("unk_err", 16'(o_Err_Count), 16'h01);
        check("unk_cmd", 16'(o_Cmd_Count), 16'h04);

        // WRITE_REG aborted by CS rise
        rx(8'h81);
        @(negedge i_Clk);
        i_CS_n  = 1'b1;
        seen_dv = 1'b0;
        repeat (5) begin
            @(negedge i_Clk);
            if (o_TX_DV) seen_dv = 1'b1;
        end
        check("abort_no_dv", 16'(seen_dv), 16'h0);
        check("abort_err", 16'(o_Err_Count), 16'h02);
        check("abort_reg", 16'(o_Reg), 16'h5C);
        check("abort_cmd", 16'(o_Cmd_Count), 16'h05);
        i_CS_n = 1'b0;
        repeat (4) @(negedge i_Clk);
        i_State = 2'b01;
        rx(8'hFF);
        check("post_abort_byte", 16'(o_TX_Byte), 16'h01);
        check("post_abort_cmd", 16'(o_Cmd_Count), 16'h06);

        // Command counter wrap through 256 GET_COUNT
        do_reset();
        for (int i = 0; i < 256; i++) begin
            rx(8'h02);
            check("gc_reply", 16'(o_TX_Byte), 16'(i));
        end
        check("gc_wrap", 16'(o_Cmd_Count), 16'h00);

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
            rx(8'h37);
            if (i == 253) check("err_254", 16'(o_Err_Count), 16'hFE);
        end
        check("err_sat", 16'(o_Err_Count), 16'hFF);
        check("err_sat_cmd", 16'(o_Cmd_Count), 16'h00);

        // Reset in WAIT_ARG coinciding with RX_DV
        rx(8'h81);
        @(negedge i_Clk);
        i_Rst     = 1'b1;
        i_RX_DV   = 1'b1;
        i_RX_Byte = 8'h5C;
        @(negedge i_Clk);
        i_Rst   = 1'b0;
        i_RX_DV = 1'b0;
        check("wrst_dv", 16'(o_TX_DV), 16'h0);
        check("wrst_byte", 16'(o_TX_Byte), 16'h00);
        check("wrst_reg", 16'(o_Reg), 16'h00);
        check("wrst_cmd", 16'(o_Cmd_Count), 16'h00);
        check("wrst_err", 16'(o_Err_Count), 16'h00);
        rx(8'hFF);
        check("wrst_idle", 16'(o_TX_Byte), 16'h01);
        check("wrst_cmd1", 16'(o_Cmd_Count), 16'h01);

        // CS rise in the same cycle as an ECHO opcode: opcode dropped
        @(negedge i_Clk);
        i_CS_n = 1'b1;
        @(negedge i_Clk);
        @(negedge i_Clk);
        i_RX_DV   = 1'b1;
        i_RX_Byte = 8'hA5;
        @(negedge i_Clk);
        i_RX_DV = 1'b0;
        check("csrx_dv", 16'(o_TX_DV), 16'h0);
        check("csrx_cmd", 16'(o_Cmd_Count), 16'h02);
        repeat (3) @(negedge i_Clk);
        check("csrx_err", 16'(o_Err_Count), 16'h00);
        i_CS_n = 1'b0;
        repeat (4) @(negedge i_Clk);
        rx(8'h5C);
        check("csrx_next_byte", 16'(o_TX_Byte), 16'hEE);
        check("csrx_next_err", 16'(o_Err_Count), 16'h01);

        // CS rise in IDLE has no effect
        @(negedge i_Clk);
        i_CS_n = 1'b1;
        repeat (5) @(negedge i_Clk);
        check("cs_idle_err", 16'(o_Err_Count), 16'h01);
        check("cs_idle_cmd", 16'(o_Cmd_Count), 16'h02);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_cmd_handler.md
# spi_cmd_handler

Command decoder and response builder sitting directly behind the SPI slave on the FPGA board. It consumes each received byte (RX valid pulse plus byte), decodes the master's command set, and loads the reply byte into the slave's TX buffer with a one-cycle TX valid pulse. The reply is shifted out on MISO during the master's next byte transfer. It also owns a small scratch register and command/error counters for bring-up with the ESP32 master.

## Interface
- STATE_WIDTH, 2, width of the FSM state input; zero-extended to 8 bits in replies.
- ERR_BYTE, 8'hEE, reply loaded for an unrecognised command.
- ACK_BYTE, 8'hAC, reply loaded after a completed WRITE_REG.

Ports:
- i_Clk  in  1  system clock (the 25 MHz divided clock); all logic on its rising edge.
- i_Rst  in  1  synchronous, active-high reset.
- i_RX_DV  in  1  one-cycle pulse from the SPI slave: i_RX_Byte valid.
- i_RX_Byte  in  8  received byte.
- i_CS_n  in  1  raw SPI chip select (asynchronous); synchronised internally.
- i_State  in  STATE_WIDTH  current FSM state.
- o_TX_DV  out  1  one-cycle pulse: load o_TX_Byte into the slave TX buffer.
- o_TX_Byte  out  8  reply byte; holds its value between pulses.
- o_Reg  out  8  scratch register written by WRITE_REG.
- o_Cmd_Count  out  8  count of accepted command bytes; wraps.
- o_Err_Count  out  8  count of errors; saturates at 8'hFF.

## Operation
- States: IDLE and WAIT_ARG. A latched pending opcode (WRITE_REG or ECHO) is held in WAIT_ARG.
- In IDLE, on i_RX_DV, the byte is decoded as follows:
  - 8'hFF GET_STATE: reply {zero pad, i_State}, with i_State sampled in the i_RX_DV cycle; o_Cmd_Count+1.
  - 8'h01 READ_REG: reply o_Reg; o_Cmd_Count+1.
  - 8'h02 GET_COUNT: reply the o_Cmd_Count value before this increment; o_Cmd_Count+1.
  - 8'h81 WRITE_REG and 8'hA5 ECHO: no reply; o_Cmd_Count+1; go to WAIT_ARG.
  - 8'h00 NOP: no reply, no count, no state change. Masters use NOP as the dummy byte that clocks out the previous reply.
  - Any other value: reply ERR_BYTE; o_Err_Count+1.
- In WAIT_ARG, on i_RX_DV, the byte is an argument, not a command, and is never counted in o_Cmd_Count:
  - WRITE_REG: o_Reg <= byte; reply ACK_BYTE; return to IDLE.
  - ECHO: reply is the byte itself; return to IDLE.
- i_CS_n passes through a 2-flop synchroniser (reset value 1), then a rising-edge detector.
- CS rising edge in WAIT_ARG with no i_RX_DV: abort. Return to IDLE, no reply, o_Reg unchanged, o_Err_Count+1.
- CS rising edge in IDLE: no effect.
- CS rising edge in the same cycle as i_RX_DV: the byte is processed fully (reply, counters, o_Reg). The next state is forced to IDLE, so an ECHO or WRITE_REG opcode in that cycle is dropped. No abort error is counted.
- o_Cmd_Count wraps from 8'hFF to 8'h00. o_Err_Count holds at 8'hFF.

## Timing
- Reset (i_Rst high at a clock edge):
  - State IDLE; o_TX_DV=0, o_TX_Byte=0, o_Reg=0, o_Cmd_Count=0, o_Err_Count=0.
  - Synchroniser flops =1, so no spurious edge appears after reset.
  - Reset overrides any concurrent i_RX_DV. A reset in WAIT_ARG discards the pending opcode without an error count.
- Reply latency: o_TX_DV is high exactly one cycle, the cycle after the i_RX_DV edge, with o_TX_Byte valid in the same cycle.
- Counter and o_Reg updates become visible the cycle after i_RX_DV.
- A new i_RX_DV may arrive on every cycle; each is processed independently with no stall.
- CS edge detection lags the pin by 2–3 cycles.

## Test plan
- Reset, then RX 8'hFF with i_State=2'b10: one cycle later o_TX_DV=1 and o_TX_Byte=8'h02; o_Cmd_Count=1.
- RX 8'h81 then 8'h5C: no TX_DV after the first byte; after the second, o_TX_Byte=8'hAC and o_Reg=8'h5C. A following RX 8'h01 replies 8'h5C; o_Cmd_Count=2 after the first two bytes and 3 after READ_REG.
- RX 8'hA5 then 8'hFF: reply 8'hFF as an echo, o_Cmd_Count not incremented by the argument. RX 8'h00: no o_TX_DV, counters unchanged.
- RX 8'h37: reply 8'hEE, o_Err_Count=1. Then RX 8'h81 followed by a CS rise with no data: state returns to IDLE, o_Err_Count=2, o_Reg unchanged, and the next RX 8'hFF replies with the state.
- Send 256 GET_COUNT commands: the last reply is 8'hFF and o_Cmd_Count wraps to 8'h00. Send 300 unknown bytes: o_Err_Count saturates at 8'hFF.
- Assert i_Rst while in WAIT_ARG and in the same cycle as i_RX_DV: all outputs are 0 next cycle, no o_TX_DV, state IDLE.
